sprite_blitter: RTL and testbench

Scan-side consumer of the 51x60 sprite ROM: converts the display's pixel scan stream into ROM row addresses, realigns the ROM's 1-cycle read latency, and emits a per-pixel "sprite on" bit for the pixel mux. Sprite position is double-buffered so it changes only at frame start. Also detects sprite/background overlap (collision) per frame for game logic.

---
 rtl/sprite_pkg.sv | 9 +
 rtl/sprite_blitter.sv | 102 ++++++++++
 tb/tb_sprite_blitter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite geometry constants and coordinate type for the sprite blitter.
package sprite_pkg;
    localparam int SPR_W   = 51;
    localparam int SPR_H   = 60;
    localparam int COORD_W = 10;
    localparam int ADDR_W  = 6;
    localparam int CNT_W   = 8;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/sprite_blitter.sv
// sprite_blitter: maps the pixel scan onto sprite ROM rows, realigns ROM latency, emits per-pixel
// sprite-on and per-frame sprite/background collision status with frame-synchronous position updates.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W   = sprite_pkg::SPR_W,
    parameter int SPR_H   = sprite_pkg::SPR_H,
    parameter int COORD_W = sprite_pkg::COORD_W,
    parameter int ADDR_W  = sprite_pkg::ADDR_W,
    parameter int CNT_W   = sprite_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pos_load,
    input  logic [COORD_W-1:0] pos_x_in,
    input  logic [COORD_W-1:0] pos_y_in,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               bg_on,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [SPR_W-1:0]   rom_data,
    output logic               pixel_valid,
    output logic               pixel_on,
    output logic               collide,
    output logic               collide_last,
    output logic [CNT_W-1:0]   hit_count
);
    localparam int COL_W = $clog2(SPR_W);
    localparam logic signed [COORD_W:0] W_LIM = (COORD_W+1)'(SPR_W);
    localparam logic signed [COORD_W:0] H_LIM = (COORD_W+1)'(SPR_H);

    logic [COORD_W-1:0] sh_x_q, sh_y_q, act_x_q, act_y_q;
    logic [COORD_W-1:0] sh_x_d, sh_y_d, act_x_d, act_y_d;
    logic               v1_q, in1_q, bg1_q, pv_q, on_q, bg2_q, col_q, last_q;
    logic               on_d, col_d, last_d;
    logic [COL_W-1:0]   col1_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [COORD_W:0] dx, dy;
    logic               inside0, hit;
    logic [SPR_W-1:0]   row_sh;

    // Extra sign bit keeps a sprite near the right/bottom limit from wrapping onto column/row 0.
    assign dx      = $signed({1'b0, pix_x}) - $signed({1'b0, act_x_q});
    assign dy      = $signed({1'b0, pix_y}) - $signed({1'b0, act_y_q});
    assign inside0 = pix_valid & ~dx[COORD_W] & (dx < W_LIM) & ~dy[COORD_W] & (dy < H_LIM);
    assign row_sh  = rom_data << col1_q;
    assign hit     = pv_q & on_q & bg2_q;

    always_comb begin
        sh_x_d   = pos_load ? pos_x_in : sh_x_q;
        sh_y_d   = pos_load ? pos_y_in : sh_y_q;
        act_x_d  = frame_start ? sh_x_d : act_x_q;
        act_y_d  = frame_start ? sh_y_d : act_y_q;
        rom_addr = inside0 ? dy[ADDR_W-1:0] : '0;
        on_d     = v1_q & in1_q & row_sh[SPR_W-1];
        col_d    = frame_start ? 1'b0 : (col_q | hit);
        last_d   = frame_start ? (col_q | hit) : last_q;
        cnt_d    = frame_start ? '0 : ((hit & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            act_x_q <= '0;
            act_y_q <= '0;
            v1_q    <= 1'b0;
            in1_q   <= 1'b0;
            col1_q  <= '0;
            bg1_q   <= 1'b0;
            pv_q    <= 1'b0;
            on_q    <= 1'b0;
            bg2_q   <= 1'b0;
            col_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sh_x_q  <= sh_x_d;
            sh_y_q  <= sh_y_d;
            act_x_q <= act_x_d;
            act_y_q <= act_y_d;
            v1_q    <= pix_valid;
            in1_q   <= inside0;
            col1_q  <= dx[COL_W-1:0];
            bg1_q   <= bg_on;
            pv_q    <= v1_q;
            on_q    <= on_d;
            bg2_q   <= bg1_q;
            col_q   <= col_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pixel_valid  = pv_q;
    assign pixel_on     = on_q;
    assign collide      = col_q;
    assign collide_last = last_q;
    assign hit_count    = cnt_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized and directed checks of sprite_blitter against a coordinate-level model.
module tb_sprite_blitter;
    import sprite_pkg::*;

    logic               clk = 0, rst = 1;
    logic               frame_start = 0, pos_load = 0, pix_valid = 0, bg_on = 0;
    coord_t             pos_x_in = '0, pos_y_in = '0, pix_x = '0, pix_y = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [SPR_W-1:0]   rom_data = '0;
    logic               pixel_valid, pixel_on, collide, collide_last;
    logic [CNT_W-1:0]   hit_count;
    logic [SPR_W-1:0]   rom [0:63];

    typedef struct {bit v; bit on; bit bg;} ent_t;
    ent_t d1, d2;
    int n_vec = 0, n_err = 0, seen_on = 0;
    int act_x, act_y, sh_x, sh_y, m_cnt;
    bit m_col, m_last;

    sprite_blitter dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pos_load(pos_load),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .bg_on(bg_on), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_valid(pixel_valid), .pixel_on(pixel_on), .collide(collide),
        .collide_last(collide_last), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic model_reset();
        act_x = 0; act_y = 0; sh_x = 0; sh_y = 0; m_cnt = 0; m_col = 0; m_last = 0;
        d1 = '{0, 0, 0}; d2 = '{0, 0, 0};
    endtask

    // One scan cycle: check outputs, drive inputs, check rom_addr, advance the model one clock.
    task automatic cyc(input bit v, input int x, input int y, input bit bg,
                       input bit fs = 0, input bit pl = 0, input int px = 0, input int py = 0);
        int dx, dy, ea;
        bit ins, hit;
        n_vec++;
        if (pixel_valid !== d2.v || pixel_on !== d2.on) begin
            n_err++;
            $display("FAIL pixel: got valid=%b on=%b want valid=%b on=%b", pixel_valid, pixel_on, d2.v, d2.on);
        end
        n_vec++;
        if (collide !== m_col || collide_last !== m_last || hit_count !== CNT_W'(m_cnt)) begin
            n_err++;
            $display("FAIL collide: got c=%b last=%b cnt=%0d want c=%b last=%b cnt=%0d",
                     collide, collide_last, hit_count, m_col, m_last, m_cnt);
        end
        if (pixel_on === 1'b1) seen_on++;
        frame_start = fs; pos_load = pl; pos_x_in = COORD_W'(px); pos_y_in = COORD_W'(py);
        pix_valid = v; pix_x = COORD_W'(x); pix_y = COORD_W'(y); bg_on = bg;
        dx = x - act_x; dy = y - act_y;
        ins = v && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
        ea = ins ? dy : 0;
        #1;
        n_vec++;
        if (rom_addr !== ADDR_W'(ea)) begin
            n_err++;
            $display("FAIL rom_addr: x=%0d y=%0d got %0d want %0d", x, y, rom_addr, ea);
        end
        hit = d2.v && d2.on && d2.bg;
        if (fs) begin m_last = m_col | hit; m_col = 0; m_cnt = 0; end
        else if (hit) begin m_col = 1; if (m_cnt < 255) m_cnt++; end
        if (pl) begin sh_x = px; sh_y = py; end
        if (fs) begin act_x = sh_x; act_y = sh_y; end
        d2 = d1;
        d1.v = v; d1.on = ins ? rom[dy][SPR_W-1-dx] : 1'b0; d1.bg = bg;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic scan_row(input int y, input int x0, input int x1, input int bg_lo = 1, input int bg_hi = 0);
        for (int x = x0; x <= x1; x++) cyc(1, x, y, (x >= bg_lo && x <= bg_hi));
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (pixel_valid !== 0 || pixel_on !== 0 || collide !== 0 || collide_last !== 0 || hit_count !== 0) begin
            n_err++;
            $display("FAIL reset_init: got pv=%b on=%b c=%b l=%b cnt=%0d want all 0",
                     pixel_valid, pixel_on, collide, collide_last, hit_count);
        end
        n_vec++;
        if (rom_addr !== 0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        model_reset();
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_row0();
        cyc(0, 0, 0, 0, 1, 1, 100, 50);
        seen_on = 0;
        scan_row(50, 99, 151);
        idle(2);
        n_vec++;
        if (seen_on !== 1) begin n_err++; $display("FAIL row0_count: got %0d want 1", seen_on); end
    endtask

    task automatic test_row15();
        seen_on = 0;
        scan_row(65, 99, 151);
        idle(2);
        n_vec++;
        if (seen_on !== SPR_W) begin n_err++; $display("FAIL row15_count: got %0d want %0d", seen_on, SPR_W); end
    endtask

    task automatic test_shadow();
        cyc(0, 0, 0, 0, 0, 1, 200, 10);
        seen_on = 0;
        scan_row(65, 99, 151);
        idle(2);
        n_vec++;
        if (seen_on !== SPR_W) begin n_err++; $display("FAIL shadow_hold: got %0d want %0d", seen_on, SPR_W); end
        cyc(0, 0, 0, 0, 1);
        seen_on = 0;
        scan_row(25, 199, 251);
        idle(2);
        n_vec++;
        if (seen_on !== SPR_W) begin n_err++; $display("FAIL shadow_move: got %0d want %0d", seen_on, SPR_W); end
    endtask

    task automatic test_collision();
        cyc(0, 0, 0, 0, 1, 1, 100, 50);
        scan_row(65, 99, 151, 120, 130);
        idle(2);
        n_vec++;
        if (hit_count !== 11 || collide !== 1) begin
            n_err++; $display("FAIL collision: got cnt=%0d c=%b want cnt=11 c=1", hit_count, collide);
        end
        cyc(0, 0, 0, 0, 1);
        n_vec++;
        if (collide_last !== 1 || collide !== 0 || hit_count !== 0) begin
            n_err++;
            $display("FAIL frame_clear: got last=%b c=%b cnt=%0d want 1 0 0", collide_last, collide, hit_count);
        end
        idle(1);
    endtask

    task automatic test_no_wrap();
        cyc(0, 0, 0, 0, 1, 1, 1020, 0);
        seen_on = 0;
        for (int y = 0; y < 20; y++) scan_row(y, 0, 5);
        idle(2);
        n_vec++;
        if (seen_on !== 0) begin n_err++; $display("FAIL no_wrap: got %0d on pixels want 0", seen_on); end
        seen_on = 0;
        scan_row(15, 1016, 1023);
        idle(2);
        n_vec++;
        if (seen_on !== 4) begin n_err++; $display("FAIL edge_clip: got %0d want 4", seen_on); end
    endtask

    task automatic test_saturate();
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        for (int r = 0; r < 6; r++) scan_row(15, 0, SPR_W - 1, 0, 1023);
        idle(2);
        n_vec++;
        if (hit_count !== 255 || collide !== 1) begin
            n_err++; $display("FAIL saturate: got cnt=%0d c=%b want 255 1", hit_count, collide);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bit fs, pl, v;
            int px, py, x, y;
            fs = ($urandom_range(0, 39) == 0);
            pl = ($urandom_range(0, 19) == 0);
            px = $urandom_range(0, 1) ? $urandom_range(0, 200) : $urandom_range(980, 1023);
            py = $urandom_range(0, 1) ? $urandom_range(0, 200) : $urandom_range(980, 1023);
            v  = ($urandom_range(0, 4) != 0);
            x  = (act_x + $urandom_range(0, 70) - 10) & 1023;
            y  = (act_y + $urandom_range(0, 75) - 8) & 1023;
            cyc(v, x, y, $urandom_range(0, 1), fs, pl, px, py);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 0, 1, 1, 100, 50);
        scan_row(65, 118, 124, 0, 1023);
        pix_valid = 0;
        rst = 1;
        #1;
        n_vec++;
        if (pixel_valid !== 0 || pixel_on !== 0 || collide !== 0 || collide_last !== 0 || hit_count !== 0) begin
            n_err++;
            $display("FAIL reset_mid: got pv=%b on=%b c=%b l=%b cnt=%0d want all 0",
                     pixel_valid, pixel_on, collide, collide_last, hit_count);
        end
        n_vec++;
        if (rom_addr !== 0) begin n_err++; $display("FAIL reset_mid_addr: got %0d want 0", rom_addr); end
        @(negedge clk);
        model_reset();
        rst = 0;
        scan_row(15, 0, 3);
        idle(2);
    endtask

    initial begin
        for (int r = 0; r < 64; r++) rom[r] = (r < SPR_H) ? {$urandom, $urandom} : '0;
        rom[0]  = '0;
        rom[0][SPR_W-1-25] = 1'b1;
        rom[15] = '1;
        model_reset();
        test_reset();
        test_row0();
        test_row15();
        test_shadow();
        test_collision();
        test_no_wrap();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
